seq_alu: RTL

//  Parametrised, registered ALU for the multi-cycle datapath. Executes the base integer ops
//  (add/sub/and/or/nor/slt) in one cycle and unsigned multiply/divide iteratively.

---
 rtl/seq_alu_pkg.sv | 23 ++
 rtl/seq_alu_if.sv | 28 ++
 rtl/seq_alu_muldiv.sv | 95 +++++++++
 rtl/seq_alu.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// Shared opcode constants, FSM state encoding and op classification for seq_alu.
// Mul/div support is gated by the SEQ_ALU_MULDIV_EN macro in the consuming files.
package seq_alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_NOR  = 4'b0100;
  localparam logic [3:0] ALU_SLTU = 4'b0101;
  localparam logic [3:0] ALU_SLT  = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b0111;
  localparam logic [3:0] ALU_MULU = 4'b1000;
  localparam logic [3:0] ALU_DIVU = 4'b1001;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_CALC = 1'b1;

  function automatic logic is_multicycle(input logic [3:0] op);
    return (op == ALU_MULU) || (op == ALU_DIVU);
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Start/busy/done handshake and operand/result bundle between the control FSM and seq_alu.
// The master drives the operation; the slave (the ALU) returns results and status.
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       ALUOp;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output start, ALUOp, A, B,
    input  result, zero, overflow, busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, ALUOp, A, B,
    output result, zero, overflow, busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/seq_alu_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider sharing one WIDTH+1 adder.
// Only compiled when SEQ_ALU_MULDIV_EN is defined.
`ifdef SEQ_ALU_MULDIV_EN
module seq_alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             dbz_load_i,
  input  logic             step_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             last_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] lo_next_o
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opb_q;
  logic             div_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   add_a, add_b;
  logic             add_cin;
  logic [WIDTH+1:0] add_s;

  // Divide: trial subtract of the divisor from {rem, next dividend bit}; carry-out = no borrow.
  always_comb begin
    if (div_q) begin
      add_a   = {hi_q, lo_q[WIDTH-1]};
      add_b   = ~{1'b0, opb_q};
      add_cin = 1'b1;
    end else begin
      add_a   = {1'b0, hi_q};
      add_b   = lo_q[0] ? {1'b0, opb_q} : '0;
      add_cin = 1'b0;
    end
    add_s = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH+1){1'b0}}, add_cin};
  end

  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    cnt_d = cnt_q;
    if (load_i) begin
      hi_d  = '0;
      lo_d  = a_i;
      cnt_d = '0;
    end else if (dbz_load_i) begin
      hi_d = a_i;
      lo_d = '1;
    end else if (step_i) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (div_q) begin
        if (add_s[WIDTH+1]) begin
          hi_d = add_s[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_d = add_a[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        hi_d = add_s[WIDTH:1];
        lo_d = {add_s[0], lo_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hi_q  <= '0;
      lo_q  <= '0;
      opb_q <= '0;
      div_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_d;
      if (load_i) begin
        opb_q <= b_i;
        div_q <= div_i;
      end
    end
  end

  assign last_o    = (cnt_q == CNT_W'(WIDTH - 1));
  assign hi_o      = hi_q;
  assign lo_o      = lo_q;
  assign lo_next_o = lo_d;

endmodule
`endif

// File: rtl/seq_alu.sv
// Registered multi-cycle ALU with start/busy/done handshake; single-cycle ops plus optional
// iterative MULU/DIVU enabled by defining SEQ_ALU_MULDIV_EN.
//   state  | meaning
//   S_IDLE | waiting for start; single-cycle ops and DIVU-by-zero complete here
//   S_CALC | mul/div iterating, one bit per cycle, busy high
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic      CLK,
  input  logic      Reset,
  seq_alu_if.slave  bus
);
  logic [WIDTH-1:0] a, b, b_neg;
  logic [3:0]       op;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ovf_q, ovf_d, done_q, done_d, dbz_q, dbz_d;

  assign a  = bus.A;
  assign b  = bus.B;
  assign op = bus.ALUOp;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    b_neg   = ~b + WIDTH'(1);
    case (op)
      ALU_ADD: begin
        alu_res = a + b;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        alu_res = a + b_neg;
        alu_ovf = (a[WIDTH-1] == b_neg[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND:  alu_res = a & b;
      ALU_OR:   alu_res = a | b;
      ALU_NOR:  alu_res = ~(a | b);
      ALU_XOR:  alu_res = a ^ b;
      ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default:  alu_res = '0;
    endcase
  end

`ifdef SEQ_ALU_MULDIV_EN
  logic             md_load, md_dbz_load, md_step, md_last;
  logic [WIDTH-1:0] md_hi, md_lo, md_lo_next;

  seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk_i      (CLK),
    .rst_i      (Reset),
    .load_i     (md_load),
    .dbz_load_i (md_dbz_load),
    .step_i     (md_step),
    .div_i      (op == ALU_DIVU),
    .a_i        (a),
    .b_i        (b),
    .last_o     (md_last),
    .hi_o       (md_hi),
    .lo_o       (md_lo),
    .lo_next_o  (md_lo_next)
  );
`endif

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    dbz_d    = dbz_q;
`ifdef SEQ_ALU_MULDIV_EN
    md_load     = 1'b0;
    md_dbz_load = 1'b0;
    md_step     = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          dbz_d = 1'b0;
          ovf_d = 1'b0;
`ifdef SEQ_ALU_MULDIV_EN
          if (is_multicycle(op)) begin
            if (op == ALU_DIVU && b == '0) begin
              md_dbz_load = 1'b1;
              result_d    = '1;
              dbz_d       = 1'b1;
              done_d      = 1'b1;
            end else begin
              md_load = 1'b1;
              state_d = S_CALC;
            end
          end else
`endif
          begin
            result_d = alu_res;
            ovf_d    = alu_ovf;
            done_d   = 1'b1;
          end
        end
      end
`ifdef SEQ_ALU_MULDIV_EN
      S_CALC: begin
        md_step = 1'b1;
        if (md_last) begin
          result_d = md_lo_next;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign bus.result      = result_q;
  assign bus.zero        = (result_q == '0);
  assign bus.overflow    = ovf_q;
  assign bus.busy        = (state_q == S_CALC);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
`ifdef SEQ_ALU_MULDIV_EN
  assign bus.hi = md_hi;
  assign bus.lo = md_lo;
`else
  assign bus.hi = '0;
  assign bus.lo = '0;
`endif

endmodule
